// File: rtl/tinker_core_cpu.sv
// tinker_core_cpu: multi-cycle 64-bit Tinker ISA core.
// Contains the 32 x 64-bit register file, a FETCH/EXEC/HALT control FSM and a
// byte-addressed, little-endian unified instruction/data memory (instance mem).
// Every instruction takes two cycles: FETCH latches IR, EXEC commits the
// register write, memory write and PC update on a single edge.
//
// Ports:
//   clk   - single clock, all state changes on the rising edge
//   reset - asynchronous, active-low reset (memory contents are preserved)
//   hlt   - registered halted flag, sticky until reset

// tinker_mem: unified byte memory with combinational 32-bit instruction and
// 64-bit data read ports and one synchronous 64-bit write port.
// Ports:
//   clk   - write clock
//   iaddr - instruction byte address, idata - 4 bytes little-endian
//   daddr - data byte address,        ddata - 8 bytes little-endian
//   we    - write enable, waddr/wdata - 8-byte little-endian write
module tinker_mem #(
    parameter int MEM_BYTES = 524288
) (
    input  logic        clk,
    input  logic [63:0] iaddr,
    output logic [31:0] idata,
    input  logic [63:0] daddr,
    output logic [63:0] ddata,
    input  logic        we,
    input  logic [63:0] waddr,
    input  logic [63:0] wdata
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0] bytes [0:MEM_BYTES-1];

    // Each byte of a multi-byte access wraps independently, so an access that
    // straddles the top of memory continues at address 0.
    function automatic logic [AW-1:0] wrap(input logic [63:0] a, input logic [3:0] off);
        return AW'((a + {60'd0, off}) % 64'(MEM_BYTES));
    endfunction

    always_comb begin
        idata = '0;
        for (int i = 0; i < 4; i++) begin
            idata[8*i +: 8] = bytes[wrap(iaddr, 4'(i))];
        end
    end

    always_comb begin
        ddata = '0;
        for (int i = 0; i < 8; i++) begin
            ddata[8*i +: 8] = bytes[wrap(daddr, 4'(i))];
        end
    end

    // All eight bytes commit on the same edge, so a store is never partial.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                bytes[wrap(waddr, 4'(i))] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

module tinker_core_cpu #(
    parameter int MEM_BYTES = 524288
) (
    input  logic clk,
    input  logic reset,
    output logic hlt
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    localparam logic [4:0] OP_AND    = 5'h00, OP_OR     = 5'h01, OP_XOR   = 5'h02,
                           OP_NOT    = 5'h03, OP_SHFTR  = 5'h04, OP_SHFTRI = 5'h05,
                           OP_SHFTL  = 5'h06, OP_SHFTLI = 5'h07, OP_BR    = 5'h08,
                           OP_BRR_R  = 5'h09, OP_BRR_L  = 5'h0A, OP_BRNZ  = 5'h0B,
                           OP_CALL   = 5'h0C, OP_RET    = 5'h0D, OP_BRGT  = 5'h0E,
                           OP_PRIV   = 5'h0F, OP_LOAD   = 5'h10, OP_MOV   = 5'h11,
                           OP_MOVL   = 5'h12, OP_STORE  = 5'h13, OP_ADD   = 5'h18,
                           OP_ADDI   = 5'h19, OP_SUB    = 5'h1A, OP_SUBI  = 5'h1B,
                           OP_MUL    = 5'h1C, OP_DIV    = 5'h1D;

    state_t      state, next_state;
    logic [63:0] PC;
    logic [31:0] IR;
    logic [63:0] regs [0:31];

    logic [4:0]  op, rd, rs, rt;
    logic [11:0] lit;
    logic [63:0] rd_v, rs_v, rt_v, r31_v, lit_s, lit_z;

    logic [31:0] idata;
    logic [63:0] ddata, daddr;
    logic        mem_we;
    logic [63:0] mem_waddr, mem_wdata;

    logic        reg_we, halt_now;
    logic [63:0] reg_wdata, pc_next;

    assign op    = IR[31:27];
    assign rd    = IR[26:22];
    assign rs    = IR[21:17];
    assign rt    = IR[16:12];
    assign lit   = IR[11:0];
    assign rd_v  = regs[rd];
    assign rs_v  = regs[rs];
    assign rt_v  = regs[rt];
    assign r31_v = regs[31];
    assign lit_s = {{52{lit[11]}}, lit};
    assign lit_z = {52'd0, lit};

    // The single data read port serves both load and return; kept apart from
    // the execute block so the address never depends on the read data.
    assign daddr = (op == OP_RET) ? (r31_v - 64'd8) : (rs_v + lit_s);

    tinker_mem #(.MEM_BYTES(MEM_BYTES)) mem (
        .clk   (clk),
        .iaddr (PC),
        .idata (idata),
        .daddr (daddr),
        .ddata (ddata),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata)
    );

    // Signed divide; the single overflowing case (min / -1) wraps to min.
    function automatic logic [63:0] sdiv(input logic signed [63:0] a, input logic signed [63:0] b);
        if (a == {1'b1, 63'd0} && b == -64'sd1) begin
            return a;
        end
        return a / b;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        reg_we     = 1'b0;
        reg_wdata  = rd_v;
        pc_next    = PC + 64'd4;
        mem_we     = 1'b0;
        mem_waddr  = rd_v + lit_s;
        mem_wdata  = rs_v;
        halt_now   = 1'b0;
        case (state)
            FETCH: next_state = EXEC;
            EXEC: begin
                next_state = FETCH;
                case (op)
                    OP_AND:    begin reg_we = 1'b1; reg_wdata = rs_v & rt_v; end
                    OP_OR:     begin reg_we = 1'b1; reg_wdata = rs_v | rt_v; end
                    OP_XOR:    begin reg_we = 1'b1; reg_wdata = rs_v ^ rt_v; end
                    OP_NOT:    begin reg_we = 1'b1; reg_wdata = ~rs_v; end
                    OP_SHFTR:  begin reg_we = 1'b1; reg_wdata = rs_v >> rt_v[5:0]; end
                    OP_SHFTRI: begin reg_we = 1'b1; reg_wdata = rd_v >> lit[5:0]; end
                    OP_SHFTL:  begin reg_we = 1'b1; reg_wdata = rs_v << rt_v[5:0]; end
                    OP_SHFTLI: begin reg_we = 1'b1; reg_wdata = rd_v << lit[5:0]; end
                    OP_BR:     pc_next = rd_v;
                    OP_BRR_R:  pc_next = PC + rd_v;
                    OP_BRR_L:  pc_next = PC + lit_s;
                    OP_BRNZ:   if (rs_v != 64'd0) pc_next = rd_v;
                    OP_CALL: begin
                        mem_we    = 1'b1;
                        mem_waddr = r31_v - 64'd8;
                        mem_wdata = PC + 64'd4;
                        pc_next   = rd_v;
                    end
                    OP_RET:    pc_next = ddata;
                    OP_BRGT:   if ($signed(rs_v) > $signed(rt_v)) pc_next = rd_v;
                    OP_PRIV: begin
                        // Halt freezes PC at the halt instruction itself.
                        if (lit == 12'd0) begin
                            halt_now = 1'b1;
                            pc_next  = PC;
                        end
                    end
                    OP_LOAD:   begin reg_we = 1'b1; reg_wdata = ddata; end
                    OP_MOV:    begin reg_we = 1'b1; reg_wdata = rs_v; end
                    OP_MOVL:   begin reg_we = 1'b1; reg_wdata = {rd_v[63:12], lit}; end
                    OP_STORE:  mem_we = 1'b1;
                    OP_ADD:    begin reg_we = 1'b1; reg_wdata = rs_v + rt_v; end
                    OP_ADDI:   begin reg_we = 1'b1; reg_wdata = rd_v + lit_z; end
                    OP_SUB:    begin reg_we = 1'b1; reg_wdata = rs_v - rt_v; end
                    OP_SUBI:   begin reg_we = 1'b1; reg_wdata = rd_v - lit_z; end
                    OP_MUL:    begin reg_we = 1'b1; reg_wdata = rs_v * rt_v; end
                    OP_DIV: begin
                        if (rt_v != 64'd0) begin
                            reg_we    = 1'b1;
                            reg_wdata = sdiv(rs_v, rt_v);
                        end
                    end
                    default: ;
                endcase
                if (halt_now) next_state = HALT;
            end
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC  <= '0;
            IR  <= '0;
            hlt <= 1'b0;
            for (int i = 0; i < 31; i++) begin
                regs[i] <= '0;
            end
            regs[31] <= 64'(MEM_BYTES);
        end else begin
            case (state)
                FETCH: IR <= idata;
                EXEC: begin
                    if (reg_we) regs[rd] <= reg_wdata;
                    PC <= pc_next;
                    if (halt_now) hlt <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tinker_core_cpu.sv
// Testbench for tinker_core_cpu: directed programs for reset, halt timing,
// store/load, relative and compare branches, divide-by-zero and reset during
// a store, plus random straight-line ALU programs checked against an
// instruction-level reference model.
module tb_tinker_core_cpu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hlt;
    int   checks = 0;
    int   errors = 0;

    tinker_core_cpu #(.MEM_BYTES(524288)) dut (
        .clk   (clk),
        .reset (reset),
        .hlt   (hlt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [11:0] l);
        return {op, rd, rs, rt, l};
    endfunction

    function automatic logic [63:0] get64(input logic [18:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = dut.mem.bytes[a + 19'(i)];
        return v;
    endfunction

    task automatic hold_reset();
        reset = 1'b0;
        for (int a = 0; a < 1024; a++) dut.mem.bytes[19'(a)] <= 8'h00;
        @(negedge clk);
    endtask

    task automatic put_word(input logic [18:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) dut.mem.bytes[a + 19'(i)] <= w[8*i +: 8];
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_to_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (hlt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        hold_reset();
        dut.mem.bytes[19'h200] <= 8'hA5;
        repeat (3) @(negedge clk);
        checks++; if (dut.PC !== 64'd0) begin errors++; $display("FAIL reset_pc got %h want 0", dut.PC); end
        checks++; if (dut.IR !== 32'd0) begin errors++; $display("FAIL reset_ir got %h want 0", dut.IR); end
        checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL reset_hlt got %b want 0", hlt); end
        checks++; if (dut.regs[31] !== 64'd524288) begin errors++; $display("FAIL reset_r31 got %0d want 524288", dut.regs[31]); end
        checks++; if (dut.regs[7] !== 64'd0) begin errors++; $display("FAIL reset_r7 got %h want 0", dut.regs[7]); end
        checks++; if (dut.mem.bytes[19'h200] !== 8'hA5) begin errors++; $display("FAIL reset_mem got %h want a5", dut.mem.bytes[19'h200]); end
    endtask

    task automatic test_addi_halt();
        hold_reset();
        put_word(19'd0, 32'hC8400005);
        put_word(19'd4, 32'h78000000);
        release_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL halt_early got %b want 0", hlt); end
        @(posedge clk);
        #1;
        checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL halt_edge4 got %b want 1", hlt); end
        checks++; if (dut.regs[1] !== 64'd5) begin errors++; $display("FAIL addi_r1 got %0d want 5", dut.regs[1]); end
        repeat (4) @(negedge clk);
        checks++; if (dut.PC !== 64'd4) begin errors++; $display("FAIL halt_pc got %0d want 4", dut.PC); end
        checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b want 1", hlt); end
    endtask

    task automatic test_store_load();
        bit ok;
        hold_reset();
        put_word(19'd0,  32'h90800100);
        put_word(19'd4,  32'hC8400005);
        put_word(19'd8,  32'h98820000);
        put_word(19'd12, 32'h80C40000);
        put_word(19'd16, 32'h78000000);
        release_reset();
        run_to_halt(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sl_halt got no halt want halt within 40 cycles"); end
        checks++; if (get64(19'h100) !== 64'd5) begin errors++; $display("FAIL sl_mem got %h want 5", get64(19'h100)); end
        checks++; if (get64(19'h108) !== 64'd0) begin errors++; $display("FAIL sl_overrun got %h want 0", get64(19'h108)); end
        checks++; if (dut.regs[3] !== 64'd5) begin errors++; $display("FAIL sl_r3 got %h want 5", dut.regs[3]); end
        checks++; if (dut.PC !== 64'd16) begin errors++; $display("FAIL sl_pc got %0d want 16", dut.PC); end
    endtask

    task automatic test_brr();
        bit ok;
        hold_reset();
        put_word(19'd0, 32'h50000008);
        put_word(19'd4, enc(5'h19, 5'd1, 5'd0, 5'd0, 12'd5));
        put_word(19'd8, 32'h78000000);
        release_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dut.PC !== 64'd8) begin errors++; $display("FAIL brr_pc got %0d want 8", dut.PC); end
        run_to_halt(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL brr_halt got no halt want halt"); end
        checks++; if (dut.regs[1] !== 64'd0) begin errors++; $display("FAIL brr_skip got %0d want 0", dut.regs[1]); end
    endtask

    task automatic test_brgt_div();
        bit ok;
        hold_reset();
        put_word(19'd0,  enc(5'h1B, 5'd1, 5'd0, 5'd0, 12'd1));
        put_word(19'd4,  enc(5'h19, 5'd2, 5'd0, 5'd0, 12'd1));
        put_word(19'd8,  enc(5'h19, 5'd3, 5'd0, 5'd0, 12'h40));
        put_word(19'd12, enc(5'h19, 5'd4, 5'd0, 5'd0, 12'd7));
        put_word(19'd16, enc(5'h19, 5'd6, 5'd0, 5'd0, 12'd9));
        put_word(19'd20, enc(5'h0E, 5'd3, 5'd1, 5'd2, 12'd0));
        put_word(19'd24, enc(5'h1D, 5'd4, 5'd6, 5'd5, 12'd0));
        put_word(19'd28, enc(5'h0E, 5'd3, 5'd2, 5'd1, 12'd0));
        put_word(19'd32, enc(5'h19, 5'd7, 5'd0, 5'd0, 12'd1));
        put_word(19'h40, 32'h78000000);
        release_reset();
        repeat (12) @(posedge clk);
        #1;
        checks++; if (dut.PC !== 64'd24) begin errors++; $display("FAIL brgt_nt_pc got %0d want 24", dut.PC); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dut.regs[4] !== 64'd7) begin errors++; $display("FAIL div0_rd got %0d want 7", dut.regs[4]); end
        run_to_halt(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL brgt_halt got no halt want halt"); end
        checks++; if (dut.PC !== 64'h40) begin errors++; $display("FAIL brgt_taken_pc got %h want 40", dut.PC); end
        checks++; if (dut.regs[7] !== 64'd0) begin errors++; $display("FAIL brgt_skip got %0d want 0", dut.regs[7]); end
        checks++; if (dut.regs[1] !== '1) begin errors++; $display("FAIL subi_wrap got %h want all ones", dut.regs[1]); end
    endtask

    task automatic test_reset_mid_store();
        bit ok;
        logic [31:0] st;
        st = enc(5'h13, 5'd2, 5'd1, 5'd0, 12'd0);
        hold_reset();
        put_word(19'h100, 32'hEEEEEEEE);
        put_word(19'h104, 32'hEEEEEEEE);
        put_word(19'd0,  enc(5'h12, 5'd2, 5'd0, 5'd0, 12'h100));
        put_word(19'd4,  enc(5'h12, 5'd1, 5'd0, 5'd0, 12'h05A));
        put_word(19'd8,  st);
        put_word(19'd12, 32'h78000000);
        release_reset();
        repeat (5) @(posedge clk);
        #1;
        checks++; if (dut.IR !== st) begin errors++; $display("FAIL rms_ir got %h want %h", dut.IR, st); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (dut.PC !== 64'd0) begin errors++; $display("FAIL rms_pc got %0d want 0", dut.PC); end
        checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL rms_hlt got %b want 0", hlt); end
        repeat (2) @(negedge clk);
        checks++; if (get64(19'h100) !== 64'hEEEEEEEEEEEEEEEE) begin errors++; $display("FAIL rms_mem got %h want eeeeeeeeeeeeeeee", get64(19'h100)); end
        release_reset();
        run_to_halt(30, ok);
        checks++; if (!ok || get64(19'h100) !== 64'h5A) begin errors++; $display("FAIL rms_rerun got %h halt %b want 5a halt 1", get64(19'h100), ok); end
    endtask

    task automatic test_random(input int runs);
        logic [4:0]  ops [20];
        logic [31:0] prog [40];
        logic [63:0] m [32];
        logic [4:0]  op, rd, rs, rt;
        logic [11:0] l;
        longint      sa, sb;
        bit          ok;
        int          n;
        ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h11, 5'h12,
                5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h14, 5'h1E, 5'h0F, 5'h12};
        n = 40;
        for (int r = 0; r < runs; r++) begin
            for (int k = 0; k < 32; k++) m[k] = 64'd0;
            m[31] = 64'd524288;
            for (int i = 0; i < n; i++) begin
                op = ops[$urandom_range(0, 19)];
                rd = 5'($urandom_range(0, 7));
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                l  = 12'($urandom_range(0, 4095));
                if (op == 5'h0F) l = l | 12'd1;
                prog[i] = enc(op, rd, rs, rt, l);
                case (op)
                    5'h00: m[rd] = m[rs] & m[rt];
                    5'h01: m[rd] = m[rs] | m[rt];
                    5'h02: m[rd] = m[rs] ^ m[rt];
                    5'h03: m[rd] = ~m[rs];
                    5'h04: m[rd] = m[rs] >> m[rt][5:0];
                    5'h05: m[rd] = m[rd] >> l[5:0];
                    5'h06: m[rd] = m[rs] << m[rt][5:0];
                    5'h07: m[rd] = m[rd] << l[5:0];
                    5'h11: m[rd] = m[rs];
                    5'h12: m[rd][11:0] = l;
                    5'h18: m[rd] = m[rs] + m[rt];
                    5'h19: m[rd] = m[rd] + 64'(l);
                    5'h1A: m[rd] = m[rs] - m[rt];
                    5'h1B: m[rd] = m[rd] - 64'(l);
                    5'h1C: m[rd] = m[rs] * m[rt];
                    5'h1D: begin
                        sa = m[rs];
                        sb = m[rt];
                        if (sb == 0) ;
                        else if (sb == -1) m[rd] = 64'(-sa);
                        else m[rd] = 64'(sa / sb);
                    end
                    default: ;
                endcase
            end
            hold_reset();
            for (int i = 0; i < n; i++) put_word(19'(4 * i), prog[i]);
            put_word(19'(4 * n), 32'h78000000);
            release_reset();
            run_to_halt(2 * n + 20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_halt got no halt want halt", r); end
            checks++; if (dut.PC !== 64'(4 * n)) begin errors++; $display("FAIL rand%0d_pc got %0d want %0d", r, dut.PC, 4 * n); end
            for (int k = 0; k < 32; k++) begin
                checks++;
                if (dut.regs[k] !== m[k]) begin
                    errors++;
                    $display("FAIL rand%0d_r%0d got %h want %h", r, k, dut.regs[k], m[k]);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_addi_halt();
        test_store_load();
        test_brr();
        test_brgt_div();
        test_reset_mid_store();
        test_random(6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tinker_core_cpu.md
# tinker_core_cpu

Multi-cycle, 64-bit integer core for the Tinker ISA. It is the top of the processor: it contains the 32-entry register file, the fetch/execute control, and a byte-addressed unified instruction/data memory. It runs from a program preloaded into memory until a halt instruction, then raises `hlt`.

## Interface
- `MEM_BYTES`, default 524288: memory size in bytes. Also the reset value of r31, the stack pointer.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `hlt`  out  1  halted flag; registered and sticky until reset.
- Hierarchy names fixed for benches:
  - memory instance `mem`, containing byte array `bytes[0:MEM_BYTES-1]`;
  - program counter `PC` (64-bit);
  - instruction register `IR` (32-bit).

## Operation
- Reset asserted (`reset`=0) forces:
  - `PC`=0, `IR`=0, `hlt`=0, state FETCH;
  - r0–r30=0, r31=`MEM_BYTES`.
  - Memory contents are untouched, so preloaded programs survive reset.
- Instruction fields: op=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], L=[11:0].
- Memory is little-endian. Instruction = 4 bytes at `PC`; data access = 8 bytes. All addresses are taken modulo `MEM_BYTES`.
- Logic ops (result to rd):
  - 0x00 and, 0x01 or, 0x02 xor: rs op rt.
  - 0x03 not: ~rs.
- Shift ops (logical, amount = low 6 bits):
  - 0x04 shftr: rd = rs >> rt. 0x05 shftri: rd = rd >> L.
  - 0x06 shftl: rd = rs << rt. 0x07 shftli: rd = rd << L.
- Control flow:
  - 0x08 br: PC = rd.
  - 0x09 brr: PC = PC + rd. 0x0A brr: PC = PC + sext(L).
  - 0x0B brnz: PC = (rs≠0) ? rd : PC+4.
  - 0x0C call: mem64[r31−8] = PC+4; PC = rd.
  - 0x0D return: PC = mem64[r31−8].
  - 0x0E brgt: PC = (signed rs > signed rt) ? rd : PC+4.
  - 0x0F priv: L=0 is halt; any other L is a no-op.
- Moves:
  - 0x10 load: rd = mem64[rs + sext(L)].
  - 0x11: rd = rs.
  - 0x12: rd[11:0] = L; rd[63:12] unchanged.
  - 0x13 store: mem64[rd + sext(L)] = rs.
- Arithmetic:
  - 0x18 add: rd = rs + rt. 0x19 addi: rd = rd + zext(L).
  - 0x1A sub: rd = rs − rt. 0x1B subi: rd = rd − zext(L).
  - 0x1C mul: low 64 bits of rs × rt.
  - 0x1D div: signed rs / rt; rt=0 leaves rd unchanged.
- Opcodes 0x14–0x17 (float, unsupported) and 0x1E–0x1F are no-ops.
- Every non-branch instruction, and every not-taken branch, sets PC = PC+4.
- Wrap-around: all 64-bit arithmetic wraps modulo 2^64; no flags, no traps.
- Register reads use values from before the current instruction. Example: add r1,r1,r1 doubles r1.

## Timing
- FSM states:
  - FETCH → EXEC → FETCH.
  - EXEC with halt → HALT. HALT is absorbing and is left only by reset.
- FETCH edge: IR ← {bytes[PC+3], bytes[PC+2], bytes[PC+1], bytes[PC]}.
- EXEC edge: register write, memory write and PC update all commit.
- Throughput is 2 cycles per instruction for every opcode.
- Memory reads are combinational; writes are synchronous on the EXEC edge.
- A load issued after a store reads the stored value.
- Halt: `hlt` rises on the EXEC edge of the halt instruction. After that, PC, registers and memory are frozen.
- Reset mid-instruction: the asynchronous reset aborts immediately. No partial memory write may occur.
- First FETCH is on the first rising edge after `reset` deasserts.

## Test plan
- Reset state: hold `reset`=0 → `PC`=0, `IR`=0, `hlt`=0, r31=524288. Preloaded bytes are unchanged.
- addi + halt:
  - program bytes 05 00 40 C8 (addi r1,5), then 00 00 00 78 (halt);
  - release reset → r1=5;
  - `hlt`=1 on the 4th edge after release, PC stays 4.
- Store/load round trip:
  - program: 0x90800100 (r2=0x100), 0x19 addi setting r1=5, 0x98820000 (store r1 → (r2)), 0x80C40000 (load r3 ← (r2)), halt;
  - expect bytes[0x100..0x107] = 05 00 00 00 00 00 00 00 and r3=5.
- Relative branch: word 0x50000008 (brr +8) at address 0 → next fetch from PC=8; the word at 4 never executes.
- Compare branch and divide-by-zero:
  - brgt with rs=−1, rt=1 → not taken, PC+4;
  - div with rt=0 → rd unchanged.
- Reset during EXEC of a store → memory unchanged, PC=0, `hlt`=0.
